// File: rtl/alu_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_pkg
// Purpose  : Shared encodings for the ALU issue slice. Holds the ALU operation
//            codes, the MIPS opcode/funct values recognised by the decoder,
//            the issue FSM state encodings and the state enum typedef.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_issue_pkg;

    // ALU operation codes presented on alu_aluc
    localparam logic [3:0] c_aluc_addu = 4'b0000;
    localparam logic [3:0] c_aluc_subu = 4'b0001;
    localparam logic [3:0] c_aluc_add  = 4'b0010;
    localparam logic [3:0] c_aluc_sub  = 4'b0011;
    localparam logic [3:0] c_aluc_and  = 4'b0100;
    localparam logic [3:0] c_aluc_or   = 4'b0101;
    localparam logic [3:0] c_aluc_xor  = 4'b0110;
    localparam logic [3:0] c_aluc_nor  = 4'b0111;
    localparam logic [3:0] c_aluc_lui  = 4'b1000;
    localparam logic [3:0] c_aluc_sltu = 4'b1010;
    localparam logic [3:0] c_aluc_slt  = 4'b1011;
    localparam logic [3:0] c_aluc_sra  = 4'b1100;
    localparam logic [3:0] c_aluc_srl  = 4'b1101;
    localparam logic [3:0] c_aluc_sll  = 4'b1110;

    // Primary opcodes
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_addiu = 6'b001001;
    localparam logic [5:0] c_op_slti  = 6'b001010;
    localparam logic [5:0] c_op_sltiu = 6'b001011;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_xori  = 6'b001110;
    localparam logic [5:0] c_op_lui   = 6'b001111;

    // R-type funct codes
    localparam logic [5:0] c_fn_sll  = 6'b000000;
    localparam logic [5:0] c_fn_srl  = 6'b000010;
    localparam logic [5:0] c_fn_sra  = 6'b000011;
    localparam logic [5:0] c_fn_sllv = 6'b000100;
    localparam logic [5:0] c_fn_srlv = 6'b000110;
    localparam logic [5:0] c_fn_srav = 6'b000111;
    localparam logic [5:0] c_fn_add  = 6'b100000;
    localparam logic [5:0] c_fn_addu = 6'b100001;
    localparam logic [5:0] c_fn_sub  = 6'b100010;
    localparam logic [5:0] c_fn_subu = 6'b100011;
    localparam logic [5:0] c_fn_and  = 6'b100100;
    localparam logic [5:0] c_fn_or   = 6'b100101;
    localparam logic [5:0] c_fn_xor  = 6'b100110;
    localparam logic [5:0] c_fn_nor  = 6'b100111;
    localparam logic [5:0] c_fn_slt  = 6'b101010;
    localparam logic [5:0] c_fn_sltu = 6'b101011;

    // Issue FSM state encodings
    localparam logic [1:0] c_st_idle = 2'b00;
    localparam logic [1:0] c_st_exec = 2'b01;
    localparam logic [1:0] c_st_done = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = c_st_idle,
        ST_EXEC = c_st_exec,
        ST_DONE = c_st_done
    } state_e;

    // Only the signed add/sub codes can raise an overflow trap; addi shares
    // the add code, so this covers add, sub and addi.
    function automatic logic is_ovf_op(input logic [3:0] aluc);
        return (aluc == c_aluc_add) || (aluc == c_aluc_sub);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_decode
// Purpose  : Purely combinational MIPS decoder. Maps an instruction word and
//            its register operands onto ALU operation code, operands,
//            destination register and an illegal-instruction flag.
// Ports    : instr   [31:0] in  - instruction word
//            rs      [31:0] in  - rs register value
//            rt      [31:0] in  - rt register value
//            aluc    [3:0]  out - ALU operation code (0000 when illegal)
//            a       [31:0] out - ALU operand A (shift amount for shifts)
//            b       [31:0] out - ALU operand B (shifted value for shifts)
//            dest    [4:0]  out - destination register index
//            illegal        out - instruction not recognised
// Revision : 1.0 - initial release
// ============================================================================
module alu_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [3:0]  aluc,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [4:0]  dest,
    output logic        illegal
);

    logic [5:0]  w_op;
    logic [4:0]  w_rt_idx;
    logic [4:0]  w_rd_idx;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [31:0] w_imm_sext;
    logic [31:0] w_imm_zext;
    logic        w_unused_rs_field;

    assign w_op       = instr[31:26];
    assign w_rt_idx   = instr[20:16];
    assign w_rd_idx   = instr[15:11];
    assign w_shamt    = instr[10:6];
    assign w_funct    = instr[5:0];
    assign w_imm_sext = {{16{instr[15]}}, instr[15:0]};
    assign w_imm_zext = {16'h0000, instr[15:0]};

    // The rs index is resolved by the register file upstream; only its value
    // arrives here.
    assign w_unused_rs_field = ^instr[25:21];

    always_comb begin
        aluc    = c_aluc_addu;
        a       = 32'h0;
        b       = 32'h0;
        dest    = 5'd0;
        illegal = 1'b0;

        if (w_op == c_op_rtype) begin
            dest = w_rd_idx;
            a    = rs;
            b    = rt;
            case (w_funct)
                c_fn_add:  aluc = c_aluc_add;
                c_fn_addu: aluc = c_aluc_addu;
                c_fn_sub:  aluc = c_aluc_sub;
                c_fn_subu: aluc = c_aluc_subu;
                c_fn_and:  aluc = c_aluc_and;
                c_fn_or:   aluc = c_aluc_or;
                c_fn_xor:  aluc = c_aluc_xor;
                c_fn_nor:  aluc = c_aluc_nor;
                c_fn_slt:  aluc = c_aluc_slt;
                c_fn_sltu: aluc = c_aluc_sltu;
                c_fn_sllv: aluc = c_aluc_sll;
                c_fn_srlv: aluc = c_aluc_srl;
                c_fn_srav: aluc = c_aluc_sra;
                c_fn_sll: begin
                    aluc = c_aluc_sll;
                    a    = {27'h0, w_shamt};
                end
                c_fn_srl: begin
                    aluc = c_aluc_srl;
                    a    = {27'h0, w_shamt};
                end
                c_fn_sra: begin
                    aluc = c_aluc_sra;
                    a    = {27'h0, w_shamt};
                end
                default: begin
                    illegal = 1'b1;
                    a       = 32'h0;
                    b       = 32'h0;
                    dest    = 5'd0;
                end
            endcase
        end else begin
            dest = w_rt_idx;
            a    = rs;
            case (w_op)
                c_op_addi:  begin aluc = c_aluc_add;  b = w_imm_sext; end
                c_op_addiu: begin aluc = c_aluc_addu; b = w_imm_sext; end
                c_op_slti:  begin aluc = c_aluc_slt;  b = w_imm_sext; end
                c_op_sltiu: begin aluc = c_aluc_sltu; b = w_imm_sext; end
                c_op_andi:  begin aluc = c_aluc_and;  b = w_imm_zext; end
                c_op_ori:   begin aluc = c_aluc_or;   b = w_imm_zext; end
                c_op_xori:  begin aluc = c_aluc_xor;  b = w_imm_zext; end
                c_op_lui:   begin aluc = c_aluc_lui;  b = w_imm_zext; end
                default: begin
                    illegal = 1'b1;
                    a       = 32'h0;
                    dest    = 5'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Purpose  : Single-entry ALU issue stage. Accepts one MIPS ALU instruction,
//            drives a registered operand set to an external combinational
//            ALU for one cycle, captures the result and holds it on a
//            valid/ready writeback port. Sequence IDLE -> EXEC -> DONE.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready, in_instr, in_rs_val, in_rt_val - issue side
//            alu_a, alu_b, alu_aluc                         - to ALU
//            alu_r, alu_zero/carry/negative/overflow        - from ALU
//            out_valid/out_ready, out_wdata, out_waddr, out_wen,
//            out_flags {zero,carry,negative,overflow}, out_illegal, out_exc
// Config   : ALU_ISSUE_OVF_TRAP_EN - when defined, signed add/sub/addi
//            overflow raises out_exc and suppresses the write.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs_val,
    input  logic [31:0] in_rt_val,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_aluc,
    input  logic [31:0] alu_r,
    input  logic        alu_zero,
    input  logic        alu_carry,
    input  logic        alu_negative,
    input  logic        alu_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_wdata,
    output logic [4:0]  out_waddr,
    output logic        out_wen,
    output logic [3:0]  out_flags,
    output logic        out_illegal,
    output logic        out_exc
);

    state_e      r_state;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_aluc;
    logic [4:0]  r_dest;
    logic        r_illegal;
    logic [31:0] r_wdata;
    logic [3:0]  r_flags;
    logic        r_wen;

    logic [3:0]  w_aluc;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [4:0]  w_dest;
    logic        w_illegal;
    logic        w_trap;

    alu_decode u_decode (
        .instr   (in_instr),
        .rs      (in_rs_val),
        .rt      (in_rt_val),
        .aluc    (w_aluc),
        .a       (w_a),
        .b       (w_b),
        .dest    (w_dest),
        .illegal (w_illegal)
    );

`ifdef ALU_ISSUE_OVF_TRAP_EN
    logic r_exc;

    // Illegal instructions decode to aluc 0000, so they never trap.
    assign w_trap = is_ovf_op(r_aluc) && alu_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exc <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_exc <= w_trap;
        end else if ((r_state == ST_DONE) && out_ready) begin
            r_exc <= 1'b0;
        end
    end

    assign out_exc = r_exc;
`else
    assign w_trap  = 1'b0;
    assign out_exc = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_a       <= 32'h0;
            r_b       <= 32'h0;
            r_aluc    <= c_aluc_addu;
            r_dest    <= 5'd0;
            r_illegal <= 1'b0;
            r_wdata   <= 32'h0;
            r_flags   <= 4'h0;
            r_wen     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a       <= w_a;
                        r_b       <= w_b;
                        r_aluc    <= w_aluc;
                        r_dest    <= w_dest;
                        r_illegal <= w_illegal;
                        r_state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_wdata <= alu_r;
                    r_flags <= {alu_zero, alu_carry, alu_negative, alu_overflow};
                    r_wen   <= !r_illegal && (r_dest != 5'd0) && !w_trap;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    // Write enable and illegal are per-transaction strobes;
                    // drop them once the writeback has been taken.
                    if (out_ready) begin
                        r_wen     <= 1'b0;
                        r_illegal <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_aluc    = r_aluc;
    assign out_wdata   = r_wdata;
    assign out_waddr   = r_dest;
    assign out_wen     = r_wen;
    assign out_flags   = r_flags;
    assign out_illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue
// Purpose  : Directed self-checking bench for alu_issue. Supplies a small
//            behavioural ALU (overflowing signed add/sub return zero) and
//            checks hand-computed results for a set of instructions,
//            backpressure and reset behaviour.
// Config   : ALU_ISSUE_OVF_TRAP_EN selects trap expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_aluc;
    logic [31:0] alu_r;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_negative;
    logic        alu_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_wdata;
    logic [4:0]  out_waddr;
    logic        out_wen;
    logic [3:0]  out_flags;
    logic        out_illegal;
    logic        out_exc;

    int n_checks = 0;
    int n_pass   = 0;

    // Operands seen on the ALU port during EXEC
    logic [31:0] x_a;
    logic [31:0] x_b;
    logic [3:0]  x_aluc;

    alu_issue dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_rs_val    (in_rs_val),
        .in_rt_val    (in_rt_val),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_aluc     (alu_aluc),
        .alu_r        (alu_r),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_wdata    (out_wdata),
        .out_waddr    (out_waddr),
        .out_wen      (out_wen),
        .out_flags    (out_flags),
        .out_illegal  (out_illegal),
        .out_exc      (out_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    logic [32:0] m_sum;
    logic [31:0] m_r;
    logic        m_c;
    logic        m_v;
    always_comb begin
        m_sum = 33'h0;
        m_r   = 32'h0;
        m_c   = 1'b0;
        m_v   = 1'b0;
        case (alu_aluc)
            4'b0000, 4'b0010: begin
                m_sum = {1'b0, alu_a} + {1'b0, alu_b};
                m_r   = m_sum[31:0];
                m_c   = m_sum[32];
                if (alu_aluc == 4'b0010)
                    m_v = (alu_a[31] == alu_b[31]) && (m_sum[31] != alu_a[31]);
            end
            4'b0001, 4'b0011: begin
                m_sum = {1'b0, alu_a} - {1'b0, alu_b};
                m_r   = m_sum[31:0];
                m_c   = m_sum[32];
                if (alu_aluc == 4'b0011)
                    m_v = (alu_a[31] != alu_b[31]) && (m_sum[31] != alu_a[31]);
            end
            4'b0100: m_r = alu_a & alu_b;
            4'b0101: m_r = alu_a | alu_b;
            4'b0110: m_r = alu_a ^ alu_b;
            4'b0111: m_r = ~(alu_a | alu_b);
            4'b1000: m_r = {alu_b[15:0], 16'h0000};
            4'b1010: m_r = (alu_a < alu_b) ? 32'd1 : 32'd0;
            4'b1011: m_r = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b1100: m_r = $unsigned($signed(alu_b) >>> alu_a[4:0]);
            4'b1101: m_r = alu_b >> alu_a[4:0];
            4'b1110: m_r = alu_b << alu_a[4:0];
            default: m_r = 32'h0;
        endcase
        if (m_v) m_r = 32'h0;
    end
    assign alu_r        = m_r;
    assign alu_zero     = (m_r == 32'h0);
    assign alu_carry    = m_c;
    assign alu_negative = m_r[31];
    assign alu_overflow = m_v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Offer one instruction, leave the bench #1 into the EXEC cycle and
    // record the ALU operands presented there.
    task automatic send(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        check("in_ready_before_issue", in_ready, 1);
        in_instr  = instr;
        in_rs_val = rs;
        in_rt_val = rt;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_a    = alu_a;
        x_b    = alu_b;
        x_aluc = alu_aluc;
        check("valid_low_in_exec", out_valid, 0);
    endtask

    task automatic wait_out;
        int n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("out_valid_arrives", out_valid, 1);
    endtask

    task automatic ack;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_after_ack", in_ready, 1);
    endtask

    initial begin
        logic seen_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_rs_val = 32'h0;
        in_rt_val = 32'h0;
        out_ready = 1'b0;
        x_a = 32'h0; x_b = 32'h0; x_aluc = 4'h0;

        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_wen", out_wen, 0);
        check("rst_out_illegal", out_illegal, 0);
        check("rst_out_exc", out_exc, 0);
        check("rst_out_flags", out_flags, 0);
        check("rst_out_wdata", out_wdata, 0);
        check("rst_out_waddr", out_waddr, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_aluc", alu_aluc, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // addu wraps to zero with carry
        send(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100001), 32'hFFFF_FFFF, 32'h1);
        check("addu_aluc", x_aluc, 4'b0000);
        check("addu_a", x_a, 32'hFFFF_FFFF);
        check("addu_b", x_b, 32'h1);
        wait_out;
        check("addu_wdata", out_wdata, 32'h0);
        check("addu_waddr", out_waddr, 3);
        check("addu_wen", out_wen, 1);
        check("addu_flags", out_flags, 4'b1100);
        check("addu_illegal", out_illegal, 0);
        ack;

        // add signed overflow
        send(rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'b100000), 32'h7FFF_FFFF, 32'h1);
        check("add_aluc", x_aluc, 4'b0010);
        wait_out;
        check("add_ovf_wdata", out_wdata, 32'h0);
        check("add_ovf_flags", out_flags, 4'b1001);
        check("add_ovf_waddr", out_waddr, 4);
`ifdef ALU_ISSUE_OVF_TRAP_EN
        check("add_ovf_exc", out_exc, 1);
        check("add_ovf_wen", out_wen, 0);
`else
        check("add_ovf_exc", out_exc, 0);
        check("add_ovf_wen", out_wen, 1);
`endif
        ack;

        // lui
        send(itype(6'b001111, 5'd0, 5'd5, 16'h1234), 32'h0, 32'h0);
        check("lui_aluc", x_aluc, 4'b1000);
        check("lui_b", x_b, 32'h0000_1234);
        wait_out;
        check("lui_wdata", out_wdata, 32'h1234_0000);
        check("lui_waddr", out_waddr, 5);
        check("lui_wen", out_wen, 1);
        ack;

        // sra by shamt
        send(rtype(5'd0, 5'd6, 5'd7, 5'd4, 6'b000011), 32'h0, 32'h8000_0000);
        check("sra_aluc", x_aluc, 4'b1100);
        check("sra_a", x_a, 32'd4);
        check("sra_b", x_b, 32'h8000_0000);
        wait_out;
        check("sra_wdata", out_wdata, 32'hF800_0000);
        check("sra_waddr", out_waddr, 7);
        ack;

        // sllv takes the shift amount from rs
        send(rtype(5'd2, 5'd3, 5'd13, 5'd9, 6'b000100), 32'd4, 32'd1);
        check("sllv_aluc", x_aluc, 4'b1110);
        check("sllv_a", x_a, 32'd4);
        wait_out;
        check("sllv_wdata", out_wdata, 32'h10);
        ack;

        // addi with negative immediate (sign extension)
        send(itype(6'b001000, 5'd1, 5'd8, 16'hFFFF), 32'd10, 32'h0);
        check("addi_aluc", x_aluc, 4'b0010);
        check("addi_b", x_b, 32'hFFFF_FFFF);
        wait_out;
        check("addi_wdata", out_wdata, 32'd9);
        check("addi_flags", out_flags, 4'b0100);
        check("addi_waddr", out_waddr, 8);
        check("addi_exc", out_exc, 0);
        ack;

        // ori zero-extends
        send(itype(6'b001101, 5'd1, 5'd9, 16'h8000), 32'h1, 32'h0);
        check("ori_b", x_b, 32'h0000_8000);
        wait_out;
        check("ori_wdata", out_wdata, 32'h0000_8001);
        ack;

        // slt vs sltu on the same operands
        send(rtype(5'd1, 5'd2, 5'd11, 5'd0, 6'b101010), 32'hFFFF_FFFF, 32'h1);
        check("slt_aluc", x_aluc, 4'b1011);
        wait_out;
        check("slt_wdata", out_wdata, 32'd1);
        ack;
        send(rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'b101011), 32'hFFFF_FFFF, 32'h1);
        check("sltu_aluc", x_aluc, 4'b1010);
        wait_out;
        check("sltu_wdata", out_wdata, 32'd0);
        ack;

        // destination r0 never writes
        send(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'b100001), 32'd5, 32'd6);
        wait_out;
        check("r0_wdata", out_wdata, 32'd11);
        check("r0_waddr", out_waddr, 0);
        check("r0_wen", out_wen, 0);
        ack;

        // illegal opcode and illegal funct
        send({6'b111111, 26'h0}, 32'h1234, 32'h5678);
        check("ill_op_aluc", x_aluc, 4'b0000);
        wait_out;
        check("ill_op_illegal", out_illegal, 1);
        check("ill_op_wen", out_wen, 0);
        ack;
        send(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b001000), 32'h1, 32'h2);
        wait_out;
        check("ill_fn_illegal", out_illegal, 1);
        check("ill_fn_wen", out_wen, 0);
        ack;
        check("illegal_cleared", out_illegal, 0);

        // backpressure: hold DONE for 10 cycles with a second request pending
        send(rtype(5'd1, 5'd2, 5'd9, 5'd0, 6'b100001), 32'd5, 32'd6);
        wait_out;
        @(negedge clk);
        in_instr  = rtype(5'd1, 5'd2, 5'd10, 5'd0, 6'b100001);
        in_rs_val = 32'd3;
        in_rt_val = 32'd4;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_wdata", out_wdata, 32'd11);
            check("bp_waddr", out_waddr, 9);
            check("bp_wen", out_wen, 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_released", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_second_taken", in_ready, 0);
        wait_out;
        check("bp_second_wdata", out_wdata, 32'd7);
        check("bp_second_waddr", out_waddr, 10);
        ack;

        // reset in the middle of EXEC drops the instruction
        send(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100001), 32'd1, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_wdata", out_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("mid_rst_no_valid", seen_valid, 0);
        check("mid_rst_idle", in_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
